// File: rtl/regfile_bypass_if.sv
// Bundle of the decode-side (reads, reservations) and writeback-side (writes)
// signals of the bypassing register file.
interface regfile_bypass_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] regAddress1;
    logic [ADDR_W-1:0] regAddress2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              regWrite;
    logic [ADDR_W-1:0] writeAddress;
    logic [DATA_W-1:0] writeData;
    logic              writeSpecialEn;
    logic [DATA_W-1:0] writeSpecial;
    logic [DATA_W-1:0] readSpecial;
    logic              reserveEn;
    logic [ADDR_W-1:0] reserveAddress;
    logic              busy1;
    logic              busy2;

    modport master (
        output regAddress1, regAddress2, regWrite, writeAddress, writeData,
               writeSpecialEn, writeSpecial, reserveEn, reserveAddress,
        input  readData1, readData2, readSpecial, busy1, busy2
    );

    modport slave (
        input  regAddress1, regAddress2, regWrite, writeAddress, writeData,
               writeSpecialEn, writeSpecial, reserveEn, reserveAddress,
        output readData1, readData2, readSpecial, busy1, busy2
    );
endinterface

// File: rtl/regfile_bypass.sv
// Register file with two async read ports, a general and a special write port,
// optional write-to-read forwarding, optional zero register and a pending-write scoreboard.
module regfile_bypass #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int SPECIAL_IDX = 15,
    parameter bit BYPASS      = 1'b1,
    parameter bit ZERO_R0     = 1'b0
) (
    input logic             clk,
    input logic             rst,
    regfile_bypass_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SPECIAL_A = ADDR_W'(SPECIAL_IDX);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic gen_we;
    logic spec_we;
    logic reserve_ok;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic [DATA_W-1:0] stored_s;

    // The general port owns SPECIAL_IDX when both ports target it in one cycle.
    assign gen_we     = bus.regWrite && !(ZERO_R0 && bus.writeAddress == '0);
    assign spec_we    = bus.writeSpecialEn && !(ZERO_R0 && SPECIAL_A == '0)
                        && !(bus.regWrite && bus.writeAddress == SPECIAL_A);
    assign reserve_ok = bus.reserveEn && !(ZERO_R0 && bus.reserveAddress == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (spec_we) begin
                mem[SPECIAL_A] <= bus.writeSpecial;
            end
            if (gen_we) begin
                mem[bus.writeAddress]  <= bus.writeData;
                busy[bus.writeAddress] <= 1'b0;
            end
            // Placed after the release so a same-cycle new reservation wins.
            if (reserve_ok) begin
                busy[bus.reserveAddress] <= 1'b1;
            end
        end
    end

    assign stored1  = mem[bus.regAddress1];
    assign stored2  = mem[bus.regAddress2];
    assign stored_s = mem[SPECIAL_A];

    function automatic logic [DATA_W-1:0] pick(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              reset_on,
        input logic              rw,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic              wse,
        input logic [DATA_W-1:0] ws
    );
        logic [DATA_W-1:0] value;
        value = stored;
        if (reset_on || (ZERO_R0 && addr == '0)) begin
            value = '0;
        end else if (BYPASS && rw && wa == addr) begin
            value = wd;
        end else if (BYPASS && wse && addr == SPECIAL_A) begin
            value = ws;
        end
        return value;
    endfunction

    always_comb begin
        bus.readData1   = pick(bus.regAddress1, stored1, rst, bus.regWrite, bus.writeAddress,
                               bus.writeData, bus.writeSpecialEn, bus.writeSpecial);
        bus.readData2   = pick(bus.regAddress2, stored2, rst, bus.regWrite, bus.writeAddress,
                               bus.writeData, bus.writeSpecialEn, bus.writeSpecial);
        bus.readSpecial = pick(SPECIAL_A, stored_s, rst, bus.regWrite, bus.writeAddress,
                               bus.writeData, bus.writeSpecialEn, bus.writeSpecial);
    end

    // Busy bits are never forwarded: a release becomes visible only after the edge.
    assign bus.busy1 = busy[bus.regAddress1];
    assign bus.busy2 = busy[bus.regAddress2];
endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: default, no-bypass and zero-register instances,
// with expectations queued by the driver and checked by a negedge monitor.
module tb_regfile_bypass;
    localparam int W = 16;

    localparam int A_RD1 = 0, A_RD2 = 1, A_RS = 2, A_B1 = 3, A_B2 = 4;
    localparam int B_RD1 = 5, B_RS = 6;
    localparam int C_RD1 = 7, C_RD2 = 8, C_B1 = 9, C_B2 = 10;

    logic clk;
    logic rst;

    regfile_bypass_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
    regfile_bypass_if #(.DATA_W(16), .ADDR_W(4)) if_b ();
    regfile_bypass_if #(.DATA_W(16), .ADDR_W(4)) if_c ();

    regfile_bypass #(.DATA_W(16), .ADDR_W(4), .SPECIAL_IDX(15), .BYPASS(1'b1), .ZERO_R0(1'b0))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    regfile_bypass #(.DATA_W(16), .ADDR_W(4), .SPECIAL_IDX(15), .BYPASS(1'b0), .ZERO_R0(1'b0))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    regfile_bypass #(.DATA_W(16), .ADDR_W(4), .SPECIAL_IDX(15), .BYPASS(1'b1), .ZERO_R0(1'b1))
        u_c (.clk(clk), .rst(rst), .bus(if_c));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic logic [W-1:0] actual(input int sel);
        case (sel)
            A_RD1:   return if_a.readData1;
            A_RD2:   return if_a.readData2;
            A_RS:    return if_a.readSpecial;
            A_B1:    return {15'b0, if_a.busy1};
            A_B2:    return {15'b0, if_a.busy2};
            B_RD1:   return if_b.readData1;
            B_RS:    return if_b.readSpecial;
            C_RD1:   return if_c.readData1;
            C_RD2:   return if_c.readData2;
            C_B1:    return {15'b0, if_c.busy1};
            C_B2:    return {15'b0, if_c.busy2};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [W-1:0] v, input string name);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        name_q.push_back(name);
    endtask

    // monitor: outputs are combinational, so every queued entry is due at the next negedge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            int           s;
            string        n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            a = actual(s);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_a.regWrite = 0; if_a.writeSpecialEn = 0; if_a.reserveEn = 0;
        if_b.regWrite = 0; if_b.writeSpecialEn = 0; if_b.reserveEn = 0;
        if_c.regWrite = 0; if_c.writeSpecialEn = 0; if_c.reserveEn = 0;
    endtask

    task automatic zero_if_inputs();
        if_a.regAddress1 = 0; if_a.regAddress2 = 0; if_a.writeAddress = 0; if_a.writeData = 0;
        if_a.writeSpecial = 0; if_a.reserveAddress = 0;
        if_b.regAddress1 = 0; if_b.regAddress2 = 0; if_b.writeAddress = 0; if_b.writeData = 0;
        if_b.writeSpecial = 0; if_b.reserveAddress = 0;
        if_c.regAddress1 = 0; if_c.regAddress2 = 0; if_c.writeAddress = 0; if_c.writeData = 0;
        if_c.writeSpecial = 0; if_c.reserveAddress = 0;
        idle_all();
    endtask

    task automatic randomize_a();
        if_a.regAddress1    = 4'($urandom_range(0, 15));
        if_a.regAddress2    = 4'($urandom_range(0, 15));
        if_a.regWrite       = 1'($urandom_range(0, 1));
        if_a.writeAddress   = 4'($urandom_range(0, 15));
        if_a.writeData      = 16'($urandom_range(1, 16'hffff));
        if_a.writeSpecialEn = 1'($urandom_range(0, 1));
        if_a.writeSpecial   = 16'($urandom_range(1, 16'hffff));
        if_a.reserveEn      = 1'($urandom_range(0, 1));
        if_a.reserveAddress = 4'($urandom_range(0, 15));
    endtask

    initial begin
        rst = 1'b1;
        zero_if_inputs();

        // reset held with random inputs toggling
        for (int k = 0; k < 4; k++) begin
            step();
            randomize_a();
            expect_val(A_RD1, 16'h0000, "rst_rd1");
            expect_val(A_RD2, 16'h0000, "rst_rd2");
            expect_val(A_RS,  16'h0000, "rst_rs");
            expect_val(A_B1,  16'h0000, "rst_busy1");
            expect_val(A_B2,  16'h0000, "rst_busy2");
        end

        step();
        rst = 1'b0;
        zero_if_inputs();
        for (int i = 0; i < 16; i++) begin
            step();
            if_a.regAddress1 = 4'(i);
            if_a.regAddress2 = 4'(15 - i);
            expect_val(A_RD1, 16'h0000, "post_rst_rd1");
            expect_val(A_RD2, 16'h0000, "post_rst_rd2");
        end

        // basic write/read with bypass
        step();
        if_a.regWrite = 1; if_a.writeAddress = 14; if_a.writeData = 16'h246C; if_a.regAddress1 = 14;
        expect_val(A_RD1, 16'h246C, "wr14_bypass");
        step();
        if_a.regWrite = 0;
        expect_val(A_RD1, 16'h246C, "wr14_stored");
        step();
        expect_val(A_RD1, 16'h246C, "wr14_hold");

        // special port
        step();
        if_a.writeSpecialEn = 1; if_a.writeSpecial = 16'h1234; if_a.regAddress1 = 15;
        expect_val(A_RS,  16'h1234, "spec_bypass_rs");
        expect_val(A_RD1, 16'h1234, "spec_bypass_rd1");
        step();
        if_a.writeSpecialEn = 0;
        expect_val(A_RS,  16'h1234, "spec_rs");
        expect_val(A_RD1, 16'h1234, "spec_rd15");
        step();
        if_a.regWrite = 1; if_a.writeAddress = 15; if_a.writeData = 16'hABCD;
        if_a.writeSpecialEn = 1; if_a.writeSpecial = 16'hFFFF;
        expect_val(A_RS,  16'hABCD, "both_bypass_rs");
        expect_val(A_RD1, 16'hABCD, "both_bypass_rd1");
        step();
        idle_all();
        expect_val(A_RS,  16'hABCD, "both_rs");
        expect_val(A_RD1, 16'hABCD, "both_rd15");

        // scoreboard: reserve, release, same-cycle reserve+write
        step();
        if_a.reserveEn = 1; if_a.reserveAddress = 3; if_a.regAddress1 = 3;
        expect_val(A_B1, 16'h0000, "res3_before_edge");
        step();
        if_a.reserveEn = 0;
        expect_val(A_B1, 16'h0001, "res3_busy");
        step();
        if_a.regWrite = 1; if_a.writeAddress = 3; if_a.writeData = 16'h0003;
        expect_val(A_B1,  16'h0001, "wb3_still_busy");
        expect_val(A_RD1, 16'h0003, "wb3_bypass");
        step();
        if_a.regWrite = 0;
        expect_val(A_B1,  16'h0000, "wb3_released");
        expect_val(A_RD1, 16'h0003, "wb3_stored");
        step();
        if_a.reserveEn = 1; if_a.reserveAddress = 5;
        if_a.regWrite = 1; if_a.writeAddress = 5; if_a.writeData = 16'h5555; if_a.regAddress2 = 5;
        expect_val(A_B2, 16'h0000, "rw5_before_edge");
        step();
        idle_all();
        expect_val(A_B2,  16'h0001, "rw5_reserve_wins");
        expect_val(A_RD2, 16'h5555, "rw5_data");
        step();
        if_a.reserveEn = 1; if_a.reserveAddress = 15; if_a.regAddress2 = 15;
        step();
        if_a.reserveEn = 0; if_a.writeSpecialEn = 1; if_a.writeSpecial = 16'h7777;
        expect_val(A_B2, 16'h0001, "res15_busy");
        step();
        idle_all();
        expect_val(A_B2,  16'h0001, "special_no_release");
        expect_val(A_RD2, 16'h7777, "special_7777");

        // no-bypass instance
        step();
        if_b.regWrite = 1; if_b.writeAddress = 11; if_b.writeData = 16'h0C3E; if_b.regAddress1 = 11;
        if_b.writeSpecialEn = 1; if_b.writeSpecial = 16'h4321;
        expect_val(B_RD1, 16'h0000, "nobyp_old");
        expect_val(B_RS,  16'h0000, "nobyp_rs_old");
        step();
        idle_all();
        expect_val(B_RD1, 16'h0C3E, "nobyp_new");
        expect_val(B_RS,  16'h4321, "nobyp_rs_new");

        // zero-register instance
        step();
        if_c.regWrite = 1; if_c.writeAddress = 0; if_c.writeData = 16'hFFFF;
        if_c.reserveEn = 1; if_c.reserveAddress = 0; if_c.regAddress1 = 0;
        expect_val(C_RD1, 16'h0000, "r0_bypass_zero");
        step();
        idle_all();
        expect_val(C_RD1, 16'h0000, "r0_zero");
        expect_val(C_B1,  16'h0000, "r0_never_busy");
        step();
        if_c.regWrite = 1; if_c.writeAddress = 2; if_c.writeData = 16'h00A5; if_c.regAddress2 = 2;
        if_c.reserveEn = 1; if_c.reserveAddress = 2;
        expect_val(C_RD2, 16'h00A5, "r2_bypass");
        step();
        idle_all();
        expect_val(C_RD2, 16'h00A5, "r2_stored");
        expect_val(C_B2,  16'h0001, "r2_busy");

        // asynchronous reset mid-cycle
        step();
        if_a.regAddress1 = 14; if_a.regAddress2 = 15;
        expect_val(A_RD1, 16'h246C, "pre_rst_rd14");
        expect_val(A_B2,  16'h0001, "pre_rst_busy15");
        step();
        rst = 1'b1;
        expect_val(A_RD1, 16'h0000, "async_rst_rd1");
        expect_val(A_RD2, 16'h0000, "async_rst_rd2");
        expect_val(A_RS,  16'h0000, "async_rst_rs");
        expect_val(A_B2,  16'h0000, "async_rst_busy2");
        expect_val(C_RD2, 16'h0000, "async_rst_c_rd2");
        expect_val(C_B2,  16'h0000, "async_rst_c_busy2");

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
